dut_stim_sequencer: RTL

- Controller that drives a single-output benchmark DUT through an exhaustive input sweep.
- For each vector it applies the value, waits a programmable settle time, then samples the DUT output.
- Each sampled point is emitted as a {vector, output} record over a valid/ready stream to the logging/compare stage.
- Sits between the bench top and the DUT. It replaces hand-timed stimulus with a repeatable, back-pressurable sequence.

---
 rtl/dut_seq_pkg.sv | 10 +
 rtl/dut_stim_sequencer_settle_timer.sv | 18 +
 rtl/dut_stim_sequencer.sv | 76 +++++++
 3 files changed

// File: rtl/dut_seq_pkg.sv
// dut_seq_pkg: shared types and limits for the stimulus sequencer.
package dut_seq_pkg;
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, EMIT, DONE} seq_state_e;
  localparam int REC_N_WIDTH = 1;
  localparam int SETTLE_MAX = 255;
  typedef struct packed {
    logic [REC_N_WIDTH-1:0] vec;
    logic out;
  } rec_t;
endpackage

// File: rtl/dut_stim_sequencer_settle_timer.sv
// dut_settle_timer: loadable down-counter with a zero flag.
module dut_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/dut_stim_sequencer.sv
// dut_stim_sequencer: sweeps a DUT input 0..last_vec, settles, samples and
// streams {vector, output} records over valid/ready.
module dut_stim_sequencer
  import dut_seq_pkg::*;
#(
  parameter int N_WIDTH = 1,
  parameter int SETTLE  = 1,
  parameter int CNT_W   = 8
) (
  input  logic               CK,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [N_WIDTH-1:0] last_vec,
  output logic [N_WIDTH-1:0] dut_in,
  input  logic               dut_out,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [N_WIDTH:0]   rec_data,
  output logic               busy,
  output logic               done,
  output logic               aborted
);
  localparam int SETTLE_C = SETTLE > SETTLE_MAX ? SETTLE_MAX : SETTLE;
  seq_state_e state, next;
  logic [N_WIDTH-1:0] vec, last;
  logic zero, take_abort;
  assign take_abort = abort && state != IDLE;
  always_ff @(posedge CK)
    state <= !reset ? IDLE : next;
  always_comb
    next = take_abort      ? IDLE :
           state == IDLE  ? (start ? DRIVE : IDLE) :
           state == DRIVE ? WAIT :
           state == WAIT  ? (zero ? EMIT : WAIT) :
           state == EMIT  ? (rec_ready ? (vec == last ? DONE : DRIVE) : EMIT) :
                            IDLE;
  always_comb begin
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end
  // Abort is the only path that withdraws a pending record.
  always_ff @(posedge CK)
    if (!reset) begin
      dut_in    <= '0;
      rec_valid <= 1'b0;
      rec_data  <= '0;
      aborted   <= 1'b0;
      vec       <= '0;
      last      <= '0;
    end else begin
      aborted <= take_abort;
      if (take_abort) begin
        rec_valid <= 1'b0;
        dut_in    <= '0;
      end else if (state == IDLE && start) begin
        last <= last_vec;
        vec  <= '0;
      end else if (state == DRIVE) dut_in <= vec;
      else if (state == WAIT && zero) begin
        rec_data  <= {dut_in, dut_out};
        rec_valid <= 1'b1;
      end else if (state == EMIT && rec_ready) begin
        rec_valid <= 1'b0;
        if (vec != last) vec <= vec + 1'b1;
      end
    end
  dut_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk  (CK),
    .rst_n(reset),
    .load (state == DRIVE),
    .dec  (state == WAIT),
    .value(CNT_W'(SETTLE_C - 1)),
    .zero (zero)
  );
endmodule
